// File: rtl/hx8352_fill_scheduler_if.sv
// Word-level link between the fill scheduler and the HX8352 bus controller.
interface hx8352_fill_scheduler_if;
  logic        bus_busy;
  logic [15:0] bus_data;
  logic        bus_rs;
  logic        bus_step;
  logic        lcd_cs;

  modport master (input bus_busy, output bus_data, output bus_rs, output bus_step, output lcd_cs);
  modport slave  (output bus_busy, input bus_data, input bus_rs, input bus_step, input lcd_cs);
endinterface

// File: rtl/hx8352_fill_scheduler.sv
// Round-robin rectangle-fill scheduler: programs the HX8352 window, issues
// memory-write, then streams one colour word per pixel through the bus controller.
module hx8352_fill_scheduler #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned MAX_X = 239,
  parameter int unsigned MAX_Y = 399,
  parameter int unsigned GUARD = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_done,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*8-1:0]    req_x0,
  input  logic [N_REQ*8-1:0]    req_x1,
  input  logic [N_REQ*9-1:0]    req_y0,
  input  logic [N_REQ*9-1:0]    req_y1,
  input  logic [N_REQ*16-1:0]   req_color,
  output logic [N_REQ-1:0]      req_grant,
  output logic [N_REQ-1:0]      req_done,
  output logic [N_REQ-1:0]      req_err,
  hx8352_fill_scheduler_if.master bus,
  output logic                  busy,
  output logic [1:0]            active_id
);

  localparam int unsigned GW      = (GUARD > 0) ? $clog2(GUARD + 1) : 1;
  localparam logic [7:0]  MAX_X_V = MAX_X[7:0];
  localparam logic [8:0]  MAX_Y_V = MAX_Y[8:0];
  localparam logic [4:0]  PIX_IDX = 5'd17;

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_CHECK, S_ISSUE, S_WAIT, S_NEXT, S_DONE} state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [N_REQ-1:0] act_oh;
  logic [7:0]       x0_r, x1_r;
  logic [8:0]       y0_r, y1_r;
  logic [15:0]      col_r;
  logic [16:0]      pix_cnt;
  logic [4:0]       widx;
  logic [GW-1:0]    guard_cnt;

  logic             win_found;
  logic [1:0]       win_idx, win_ptr;
  logic [N_REQ-1:0] win_oh;
  logic [7:0]       sel_x0, sel_x1;
  logic [8:0]       sel_y0, sel_y1;
  logic [15:0]      sel_col;

  // Two passes give "first valid at or after ptr, then wrap" without a modulo index.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_ptr   = '0;
    win_oh    = '0;
    sel_x0    = '0;
    sel_x1    = '0;
    sel_y0    = '0;
    sel_y1    = '0;
    sel_col   = '0;
    for (int unsigned pass = 0; pass < 2; pass++) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!win_found && req_valid[i] &&
            ((pass == 0) ? (i >= 32'(ptr)) : (i < 32'(ptr)))) begin
          win_found = 1'b1;
          win_idx   = 2'(i);
          win_ptr   = 2'((i + 1) % N_REQ);
          win_oh[i] = 1'b1;
          sel_x0    = req_x0[8*i +: 8];
          sel_x1    = req_x1[8*i +: 8];
          sel_y0    = req_y0[9*i +: 9];
          sel_y1    = req_y1[9*i +: 9];
          sel_col   = req_color[16*i +: 16];
        end
      end
    end
  end

  logic        bad_rect;
  logic [8:0]  width;
  logic [9:0]  height;
  logic [16:0] area;

  always_comb begin
    bad_rect = (x1_r < x0_r) || (y1_r < y0_r) || (x1_r > MAX_X_V) || (y1_r > MAX_Y_V);
    width    = {1'b0, x1_r} - {1'b0, x0_r} + 9'd1;
    height   = {1'b0, y1_r} - {1'b0, y0_r} + 10'd1;
    area     = 17'(width) * 17'(height);
  end

  logic [15:0] word_data;
  logic        word_rs;

  always_comb begin
    word_data = col_r;
    word_rs   = 1'b1;
    case (widx)
      5'd0:  begin word_data = 16'h0002; word_rs = 1'b0; end
      5'd1:  word_data = 16'h0000;
      5'd2:  begin word_data = 16'h0003; word_rs = 1'b0; end
      5'd3:  word_data = {8'h00, x0_r};
      5'd4:  begin word_data = 16'h0004; word_rs = 1'b0; end
      5'd5:  word_data = 16'h0000;
      5'd6:  begin word_data = 16'h0005; word_rs = 1'b0; end
      5'd7:  word_data = {8'h00, x1_r};
      5'd8:  begin word_data = 16'h0006; word_rs = 1'b0; end
      5'd9:  word_data = {15'h0000, y0_r[8]};
      5'd10: begin word_data = 16'h0007; word_rs = 1'b0; end
      5'd11: word_data = {8'h00, y0_r[7:0]};
      5'd12: begin word_data = 16'h0008; word_rs = 1'b0; end
      5'd13: word_data = {15'h0000, y1_r[8]};
      5'd14: begin word_data = 16'h0009; word_rs = 1'b0; end
      5'd15: word_data = {8'h00, y1_r[7:0]};
      5'd16: begin word_data = 16'h0022; word_rs = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      ptr          <= '0;
      act_oh       <= '0;
      x0_r         <= '0;
      x1_r         <= '0;
      y0_r         <= '0;
      y1_r         <= '0;
      col_r        <= '0;
      pix_cnt      <= '0;
      widx         <= '0;
      guard_cnt    <= '0;
      req_grant    <= '0;
      req_done     <= '0;
      req_err      <= '0;
      bus.bus_data <= '0;
      bus.bus_rs   <= 1'b0;
      bus.bus_step <= 1'b0;
      bus.lcd_cs   <= 1'b1;
      busy         <= 1'b0;
      active_id    <= '0;
    end else begin
      req_grant    <= '0;
      req_done     <= '0;
      req_err      <= '0;
      bus.bus_step <= 1'b0;
      case (state)
        S_IDLE: if (init_done && |req_valid) state <= S_ARB;
        S_ARB: begin
          if (win_found) begin
            req_grant <= win_oh;
            act_oh    <= win_oh;
            active_id <= win_idx;
            busy      <= 1'b1;
            ptr       <= win_ptr;
            x0_r      <= sel_x0;
            x1_r      <= sel_x1;
            y0_r      <= sel_y0;
            y1_r      <= sel_y1;
            col_r     <= sel_col;
            state     <= S_CHECK;
          end else begin
            state <= S_IDLE;
          end
        end
        S_CHECK: begin
          if (bad_rect) begin
            req_err <= act_oh;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else begin
            bus.lcd_cs <= 1'b0;
            pix_cnt    <= area;
            widx       <= '0;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (init_done && !bus.bus_busy) begin
            bus.bus_data <= word_data;
            bus.bus_rs   <= word_rs;
            bus.bus_step <= 1'b1;
            guard_cnt    <= GW'(GUARD);
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (guard_cnt != '0)   guard_cnt <= guard_cnt - 1'b1;
          else if (!bus.bus_busy) state    <= S_NEXT;
        end
        S_NEXT: begin
          if (widx != PIX_IDX) begin
            widx  <= widx + 5'd1;
            state <= S_ISSUE;
          end else begin
            pix_cnt <= pix_cnt - 17'd1;
            state   <= (pix_cnt == 17'd1) ? S_DONE : S_ISSUE;
          end
        end
        S_DONE: begin
          req_done   <= act_oh;
          bus.lcd_cs <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
